// File: rtl/core_id_issue.sv
// Decode/issue stage: 2-entry skid queue, operand read, RAW forwarding/stall towards execute.
// Optional performance counters are enabled with `define ID_PERF_CNT_EN.
module core_id_issue #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter int RFIDX_W   = 5,
    parameter int DEC_BUS_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    output logic                 ready_in,
    input  logic [PC_W-1:0]      i_pc,
    input  logic                 i_branch_predict,
    input  logic                 i_rs1_ren,
    input  logic                 i_rs2_ren,
    input  logic                 i_rd_wen,
    input  logic [RFIDX_W-1:0]   i_rs1_idx,
    input  logic [RFIDX_W-1:0]   i_rs2_idx,
    input  logic [RFIDX_W-1:0]   i_rd_idx,
    input  logic [XLEN-1:0]      i_imm,
    input  logic [DEC_BUS_W-1:0] i_dec_bus,
    output logic [RFIDX_W-1:0]   rf_rs1_idx,
    output logic [RFIDX_W-1:0]   rf_rs2_idx,
    input  logic [XLEN-1:0]      rf_rs1_dat,
    input  logic [XLEN-1:0]      rf_rs2_dat,
    input  logic [RFIDX_W-1:0]   ex_rd_idx,
    input  logic                 ex_rd_wen,
    input  logic                 ex_wb_en,
    input  logic [XLEN-1:0]      ex_wb_dat,
    input  logic                 flush_req,
    output logic                 valid_out,
    input  logic                 ready_out,
    output logic [PC_W-1:0]      o_pc,
    output logic                 o_branch_predict,
    output logic                 o_rs1_ren,
    output logic                 o_rs2_ren,
    output logic                 o_rd_wen,
    output logic [RFIDX_W-1:0]   o_rs1_idx,
    output logic [RFIDX_W-1:0]   o_rs2_idx,
    output logic [RFIDX_W-1:0]   o_rd_idx,
    output logic [XLEN-1:0]      o_imm,
    output logic [DEC_BUS_W-1:0] o_dec_bus,
    output logic [XLEN-1:0]      o_rs1_dat,
    output logic [XLEN-1:0]      o_rs2_dat
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]          perf_issue_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic                 bp;
        logic                 rs1_ren;
        logic                 rs2_ren;
        logic                 rd_wen;
        logic [RFIDX_W-1:0]   rs1_idx;
        logic [RFIDX_W-1:0]   rs2_idx;
        logic [RFIDX_W-1:0]   rd_idx;
        logic [XLEN-1:0]      imm;
        logic [DEC_BUS_W-1:0] dec_bus;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ISSUE,
        ST_STALL
    } state_t;

    entry_t     mem [2];
    entry_t     head_e;
    logic       head;
    logic       tail;
    logic [1:0] count;
    logic       enq;
    logic       deq;
    logic       hazard_rs1;
    logic       hazard_rs2;
    state_t     issue_state;

    assign head_e   = mem[head];
    assign ready_in = (count != 2'd2);
    assign enq      = valid_in & ready_in & ~flush_req;
    assign deq      = valid_out & ready_out;

    // Pointer/occupancy bookkeeping; a flush empties the queue and drops any enqueue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (flush_req) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (enq)
                tail <= ~tail;
            if (deq)
                head <= ~head;
            count <= count + {1'b0, enq} - {1'b0, deq};
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (enq)
            mem[tail] <= '{pc: i_pc, bp: i_branch_predict, rs1_ren: i_rs1_ren,
                           rs2_ren: i_rs2_ren, rd_wen: i_rd_wen, rs1_idx: i_rs1_idx,
                           rs2_idx: i_rs2_idx, rd_idx: i_rd_idx, imm: i_imm,
                           dec_bus: i_dec_bus};
    end

    assign rf_rs1_idx = head_e.rs1_idx;
    assign rf_rs2_idx = head_e.rs2_idx;

    // Forward a ready execute result, stall on one still in flight; x0 never hazards.
    always_comb begin
        o_rs1_dat  = rf_rs1_dat;
        o_rs2_dat  = rf_rs2_dat;
        hazard_rs1 = 1'b0;
        hazard_rs2 = 1'b0;
        if (head_e.rs1_ren && (head_e.rs1_idx != '0) && ex_rd_wen && (ex_rd_idx == head_e.rs1_idx)) begin
            if (ex_wb_en)
                o_rs1_dat = ex_wb_dat;
            else
                hazard_rs1 = 1'b1;
        end
        if (head_e.rs2_ren && (head_e.rs2_idx != '0) && ex_rd_wen && (ex_rd_idx == head_e.rs2_idx)) begin
            if (ex_wb_en)
                o_rs2_dat = ex_wb_dat;
            else
                hazard_rs2 = 1'b1;
        end
    end

    // Issue state follows occupancy and hazards directly, so it resolves in the same cycle.
    always_comb begin
        issue_state = ST_EMPTY;
        if (count != 2'd0)
            issue_state = (hazard_rs1 | hazard_rs2) ? ST_STALL : ST_ISSUE;
    end

    assign valid_out        = (issue_state == ST_ISSUE) & ~flush_req;
    assign o_pc             = head_e.pc;
    assign o_branch_predict = head_e.bp;
    assign o_rs1_ren        = head_e.rs1_ren;
    assign o_rs2_ren        = head_e.rs2_ren;
    assign o_rd_wen         = head_e.rd_wen;
    assign o_rs1_idx        = head_e.rs1_idx;
    assign o_rs2_idx        = head_e.rs2_idx;
    assign o_rd_idx         = head_e.rd_idx;
    assign o_imm            = head_e.imm;
    assign o_dec_bus        = head_e.dec_bus;

`ifdef ID_PERF_CNT_EN
    // deq is already suppressed during flush, so only the stall count needs the guard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (deq)
                perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if ((issue_state == ST_STALL) && !flush_req)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_id_issue.sv
// Scoreboard bench for core_id_issue: issued instructions are popped and compared in order.
// Counter checks are compiled in when ID_PERF_CNT_EN is defined.
module tb_core_id_issue;

    typedef struct {
        logic [31:0] pc;
        logic        bp;
        logic        rs1_ren;
        logic [4:0]  rs1_idx;
        logic        rs2_ren;
        logic [4:0]  rs2_idx;
        logic [4:0]  rd_idx;
        logic [31:0] imm;
        logic [63:0] dec_bus;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [31:0] i_pc = '0;
    logic        i_branch_predict = 1'b0;
    logic        i_rs1_ren = 1'b0;
    logic        i_rs2_ren = 1'b0;
    logic        i_rd_wen = 1'b0;
    logic [4:0]  i_rs1_idx = '0;
    logic [4:0]  i_rs2_idx = '0;
    logic [4:0]  i_rd_idx = '0;
    logic [31:0] i_imm = '0;
    logic [63:0] i_dec_bus = '0;
    logic [4:0]  rf_rs1_idx;
    logic [4:0]  rf_rs2_idx;
    logic [31:0] rf_rs1_dat;
    logic [31:0] rf_rs2_dat;
    logic [4:0]  ex_rd_idx = '0;
    logic        ex_rd_wen = 1'b0;
    logic        ex_wb_en = 1'b0;
    logic [31:0] ex_wb_dat = '0;
    logic        flush_req = 1'b0;
    logic        valid_out;
    logic        ready_out = 1'b0;
    logic [31:0] o_pc;
    logic        o_branch_predict;
    logic        o_rs1_ren;
    logic        o_rs2_ren;
    logic        o_rd_wen;
    logic [4:0]  o_rs1_idx;
    logic [4:0]  o_rs2_idx;
    logic [4:0]  o_rd_idx;
    logic [31:0] o_imm;
    logic [63:0] o_dec_bus;
    logic [31:0] o_rs1_dat;
    logic [31:0] o_rs2_dat;
`ifdef ID_PERF_CNT_EN
    logic [31:0] perf_issue_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] stall_base;
`endif

    logic [31:0] regs [32];
    exp_t        sb [$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          issued = 0;

    core_id_issue dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
        .i_pc(i_pc), .i_branch_predict(i_branch_predict),
        .i_rs1_ren(i_rs1_ren), .i_rs2_ren(i_rs2_ren), .i_rd_wen(i_rd_wen),
        .i_rs1_idx(i_rs1_idx), .i_rs2_idx(i_rs2_idx), .i_rd_idx(i_rd_idx),
        .i_imm(i_imm), .i_dec_bus(i_dec_bus),
        .rf_rs1_idx(rf_rs1_idx), .rf_rs2_idx(rf_rs2_idx),
        .rf_rs1_dat(rf_rs1_dat), .rf_rs2_dat(rf_rs2_dat),
        .ex_rd_idx(ex_rd_idx), .ex_rd_wen(ex_rd_wen), .ex_wb_en(ex_wb_en),
        .ex_wb_dat(ex_wb_dat), .flush_req(flush_req),
        .valid_out(valid_out), .ready_out(ready_out),
        .o_pc(o_pc), .o_branch_predict(o_branch_predict),
        .o_rs1_ren(o_rs1_ren), .o_rs2_ren(o_rs2_ren), .o_rd_wen(o_rd_wen),
        .o_rs1_idx(o_rs1_idx), .o_rs2_idx(o_rs2_idx), .o_rd_idx(o_rd_idx),
        .o_imm(o_imm), .o_dec_bus(o_dec_bus),
        .o_rs1_dat(o_rs1_dat), .o_rs2_dat(o_rs2_dat)
`ifdef ID_PERF_CNT_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign rf_rs1_dat = (rf_rs1_idx == 5'd0) ? 32'd0 : regs[rf_rs1_idx];
    assign rf_rs2_dat = (rf_rs2_idx == 5'd0) ? 32'd0 : regs[rf_rs2_idx];

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] modelOperand(input logic ren, input logic [4:0] idx);
        if (ren && idx != 5'd0 && ex_rd_wen && ex_rd_idx == idx && ex_wb_en)
            return ex_wb_dat;
        return (idx == 5'd0) ? 32'd0 : regs[idx];
    endfunction

    function automatic exp_t makeEntry(input logic [31:0] pc, input logic r1en, input logic [4:0] r1,
                                       input logic r2en, input logic [4:0] r2);
        exp_t e;
        e.pc      = pc;
        e.bp      = pc[2];
        e.rs1_ren = r1en;
        e.rs1_idx = r1;
        e.rs2_ren = r2en;
        e.rs2_idx = r2;
        e.rd_idx  = pc[6:2] ^ 5'd9;
        e.imm     = pc ^ 32'h5A5A_0F0F;
        e.dec_bus = {~pc, pc + 32'h1234};
        return e;
    endfunction

    task automatic driveEntry(input exp_t e);
        valid_in         = 1'b1;
        i_pc             = e.pc;
        i_branch_predict = e.bp;
        i_rs1_ren        = e.rs1_ren;
        i_rs1_idx        = e.rs1_idx;
        i_rs2_ren        = e.rs2_ren;
        i_rs2_idx        = e.rs2_idx;
        i_rd_wen         = 1'b1;
        i_rd_idx         = e.rd_idx;
        i_imm            = e.imm;
        i_dec_bus        = e.dec_bus;
    endtask

    // Hold one instruction on the input until the handshake completes; push it on acceptance.
    task automatic applyStimulus(input logic [31:0] pc, input logic r1en, input logic [4:0] r1,
                                 input logic r2en, input logic [4:0] r2);
        exp_t e;
        bit   done = 0;
        e = makeEntry(pc, r1en, r1, r2en, r2);
        driveEntry(e);
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (ready_in && !flush_req) begin
                sb.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done)
            checkOutput("accept_timeout", 64'd0, 64'd1);
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && valid_out && ready_out) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_issue", {32'd0, o_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                issued++;
                checkOutput("issue_pc", {32'd0, o_pc}, {32'd0, mon_e.pc});
                checkOutput("issue_bp", {63'd0, o_branch_predict}, {63'd0, mon_e.bp});
                checkOutput("issue_rd_idx", {59'd0, o_rd_idx}, {59'd0, mon_e.rd_idx});
                checkOutput("issue_imm", {32'd0, o_imm}, {32'd0, mon_e.imm});
                checkOutput("issue_dec_bus", o_dec_bus, mon_e.dec_bus);
                checkOutput("issue_rs1_dat", {32'd0, o_rs1_dat},
                            {32'd0, modelOperand(mon_e.rs1_ren, mon_e.rs1_idx)});
                checkOutput("issue_rs2_dat", {32'd0, o_rs2_dat},
                            {32'd0, modelOperand(mon_e.rs2_ren, mon_e.rs2_idx)});
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++)
            regs[i] = (i == 0) ? 32'd0 : 32'hA000_0000 + i * 32'h111;
        regs[5] = 32'h1;

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_ready_in", {63'd0, ready_in}, 64'd1);
        checkOutput("reset_valid_out", {63'd0, valid_out}, 64'd0);
`ifdef ID_PERF_CNT_EN
        checkOutput("reset_perf_issue", {32'd0, perf_issue_cnt}, 64'd0);
        checkOutput("reset_perf_stall", {32'd0, perf_stall_cnt}, 64'd0);
`endif
        @(posedge clk);
        #1;

        $display("[TB] back-to-back issue");
        ready_out = 1'b1;
        driveEntry(makeEntry(32'h8000_0000, 1'b1, 5'd3, 1'b1, 5'd4));
        @(negedge clk);
        checkOutput("b2b_ready_in0", {63'd0, ready_in}, 64'd1);
        sb.push_back(makeEntry(32'h8000_0000, 1'b1, 5'd3, 1'b1, 5'd4));
        @(posedge clk);
        #1;
        driveEntry(makeEntry(32'h8000_0004, 1'b1, 5'd6, 1'b0, 5'd0));
        @(negedge clk);
        checkOutput("b2b_valid1", {63'd0, valid_out}, 64'd1);
        checkOutput("b2b_ready_in1", {63'd0, ready_in}, 64'd1);
        sb.push_back(makeEntry(32'h8000_0004, 1'b1, 5'd6, 1'b0, 5'd0));
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        @(negedge clk);
        checkOutput("b2b_valid2", {63'd0, valid_out}, 64'd1);
        checkOutput("b2b_ready_in2", {63'd0, ready_in}, 64'd1);
        idle(1);
        @(negedge clk);
        checkOutput("b2b_drained", {63'd0, valid_out}, 64'd0);
        idle(1);

        $display("[TB] backpressure");
        ready_out = 1'b0;
        applyStimulus(32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(32'h4, 1'b1, 5'd1, 1'b1, 5'd2);
        driveEntry(makeEntry(32'h8, 1'b1, 5'd8, 1'b0, 5'd0));
        @(negedge clk);
        checkOutput("bp_full_ready_in", {63'd0, ready_in}, 64'd0);
        checkOutput("bp_full_valid_out", {63'd0, valid_out}, 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("bp_hold_pc", {32'd0, o_pc}, 64'h0);
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        applyStimulus(32'h8, 1'b1, 5'd8, 1'b0, 5'd0);
        idle(3);

        $display("[TB] forwarding");
        ex_rd_wen = 1'b1;
        ex_rd_idx = 5'd5;
        ex_wb_en  = 1'b1;
        ex_wb_dat = 32'hDEAD_BEEF;
        applyStimulus(32'h40, 1'b1, 5'd5, 1'b1, 5'd6);
        @(negedge clk);
        checkOutput("fwd_valid_out", {63'd0, valid_out}, 64'd1);
        checkOutput("fwd_rs1_dat", {32'd0, o_rs1_dat}, 64'hDEAD_BEEF);
        checkOutput("fwd_rs2_dat", {32'd0, o_rs2_dat}, {32'd0, regs[6]});
        @(posedge clk);
        #1;
        ex_rd_wen = 1'b0;
        ex_wb_en  = 1'b0;
        idle(1);

        $display("[TB] load-use stall");
`ifdef ID_PERF_CNT_EN
        stall_base = perf_stall_cnt;
`endif
        ex_rd_wen = 1'b1;
        ex_rd_idx = 5'd7;
        ex_wb_en  = 1'b0;
        ex_wb_dat = 32'h0;
        applyStimulus(32'h80, 1'b1, 5'd7, 1'b0, 5'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("stall_valid_out%0d", c), {63'd0, valid_out}, 64'd0);
            @(posedge clk);
            #1;
        end
        ex_wb_en  = 1'b1;
        ex_wb_dat = 32'h55;
        @(negedge clk);
        checkOutput("stall_release_valid", {63'd0, valid_out}, 64'd1);
        checkOutput("stall_release_rs1", {32'd0, o_rs1_dat}, 64'h55);
`ifdef ID_PERF_CNT_EN
        checkOutput("stall_perf_cnt", {32'd0, perf_stall_cnt - stall_base}, 64'd3);
`endif
        @(posedge clk);
        #1;
        ex_rd_wen = 1'b0;
        ex_wb_en  = 1'b0;
        idle(1);

        $display("[TB] x0 source");
        ex_rd_wen = 1'b1;
        ex_rd_idx = 5'd0;
        ex_wb_en  = 1'b0;
        applyStimulus(32'hC0, 1'b0, 5'd9, 1'b1, 5'd0);
        @(negedge clk);
        checkOutput("x0_valid_out", {63'd0, valid_out}, 64'd1);
        checkOutput("x0_rs2_dat", {32'd0, o_rs2_dat}, 64'd0);
        @(posedge clk);
        #1;
        ex_rd_wen = 1'b0;
        idle(1);

        $display("[TB] flush with full queue");
        ready_out = 1'b0;
        applyStimulus(32'h100, 1'b0, 5'd0, 1'b0, 5'd0);
        applyStimulus(32'h104, 1'b0, 5'd0, 1'b0, 5'd0);
        driveEntry(makeEntry(32'h200, 1'b0, 5'd0, 1'b0, 5'd0));
        flush_req = 1'b1;
        ready_out = 1'b1;
        sb.delete();
        @(negedge clk);
        checkOutput("flush_cycle_valid", {63'd0, valid_out}, 64'd0);
        @(posedge clk);
        #1;
        flush_req = 1'b0;
        valid_in  = 1'b0;
        @(negedge clk);
        checkOutput("flush_valid_out", {63'd0, valid_out}, 64'd0);
        checkOutput("flush_ready_in", {63'd0, ready_in}, 64'd1);
        idle(2);
        @(negedge clk);
        checkOutput("flush_no_issue", {63'd0, valid_out}, 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] async reset mid-stall");
        ex_rd_wen = 1'b1;
        ex_rd_idx = 5'd12;
        ex_wb_en  = 1'b0;
        applyStimulus(32'h300, 1'b0, 5'd0, 1'b1, 5'd12);
        applyStimulus(32'h304, 1'b0, 5'd0, 1'b0, 5'd0);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("rst_async_valid", {63'd0, valid_out}, 64'd0);
        checkOutput("rst_async_ready", {63'd0, ready_in}, 64'd1);
`ifdef ID_PERF_CNT_EN
        checkOutput("rst_async_perf_issue", {32'd0, perf_issue_cnt}, 64'd0);
        checkOutput("rst_async_perf_stall", {32'd0, perf_stall_cnt}, 64'd0);
`endif
        issued = 0;
        @(negedge clk);
        rst       = 1'b0;
        ex_rd_wen = 1'b0;
        idle(1);
        @(negedge clk);
        checkOutput("rst_after_valid", {63'd0, valid_out}, 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] post-reset throughput");
        applyStimulus(32'h400, 1'b1, 5'd2, 1'b1, 5'd3);
        applyStimulus(32'h404, 1'b1, 5'd4, 1'b0, 5'd0);
        applyStimulus(32'h408, 1'b0, 5'd0, 1'b1, 5'd5);
        idle(3);
`ifdef ID_PERF_CNT_EN
        @(negedge clk);
        checkOutput("perf_issue_cnt", {32'd0, perf_issue_cnt}, {32'd0, 32'(issued)});
`endif
        checkOutput("sb_drained", {32'd0, 32'(sb.size())}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_id_issue.md
Name: core_id_issue

Overview:
- Decode/issue stage sitting directly upstream of the execute/commit stage.
- Buffers decoded instructions from fetch/decode in a 2-entry skid queue and reads source operands from the register file.
- Resolves RAW hazards against the instruction currently in execute, either by forwarding its result or by stalling.
- Drives the execute stage's valid/ready input handshake, and drops all held instructions on a commit flush.

Parameters:
- XLEN, 32, data/operand width.
- PC_W, 32, program-counter width.
- RFIDX_W, 5, register index width.
- DEC_BUS_W, 64, width of the opaque decoded-control bus (concatenated bj/alu/lsu/csr instruction buses), passed through unmodified.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  decoded instruction valid from decode.
- ready_in  out  1  issue can accept an instruction.
- i_pc  in  PC_W  instruction PC.
- i_branch_predict  in  1  fetch prediction taken flag.
- i_rs1_ren, i_rs2_ren, i_rd_wen  in  1 each  register read/write enables.
- i_rs1_idx, i_rs2_idx, i_rd_idx  in  RFIDX_W each  register indices.
- i_imm  in  XLEN  decoded immediate.
- i_dec_bus  in  DEC_BUS_W  decoded control bus.
- rf_rs1_idx, rf_rs2_idx  out  RFIDX_W  register-file read addresses (head entry).
- rf_rs1_dat, rf_rs2_dat  in  XLEN  register-file read data (combinational, x0 reads 0).
- ex_rd_idx, ex_rd_wen  in  RFIDX_W/1  destination of the instruction in execute.
- ex_wb_en  in  1  execute result valid this cycle.
- ex_wb_dat  in  XLEN  execute result.
- flush_req  in  1  commit flush.
- valid_out  out  1  head instruction issuable to execute.
- ready_out  in  1  execute accepts.
- o_pc, o_branch_predict, o_rs1_ren, o_rs2_ren, o_rd_wen, o_rs1_idx, o_rs2_idx, o_rd_idx, o_imm, o_dec_bus  out  as input widths  head-entry fields.
- o_rs1_dat, o_rs2_dat  out  XLEN  resolved operands.

Behaviour:
- Queue: 2 entries, head/tail pointers (1 bit each) plus count (0..2).
  - enq = valid_in & ready_in & ~flush_req.
  - deq = valid_out & ready_out.
  - ready_in = (count != 2); ready_in is registered-equivalent (derived from flops only).
  - Simultaneous enq and deq at count 2 is not possible, since ready_in is 0. At count 1, simultaneous enq+deq leaves count 1 and advances both pointers.
  - Pointers wrap 1→0.
- Operand resolution, per source s in {rs1, rs2}, evaluated on the head entry:
  - s_ren=0 or s_idx=0: operand = rf data (x0 yields 0); no hazard.
  - ex_rd_wen & ex_rd_idx==s_idx & ex_wb_en: operand = ex_wb_dat (forward).
  - ex_rd_wen & ex_rd_idx==s_idx & ~ex_wb_en: hazard (load or CSR in flight).
  - Otherwise: operand = rf_s_dat.
- Outputs:
  - valid_out = (count!=0) & ~hazard_rs1 & ~hazard_rs2 & ~flush_req.
  - Output fields are combinational from the head entry; they are undefined-don't-care when valid_out=0 but must be stable while valid_out=1 and ready_out=0.
- Flush: flush_req=1 at a clock edge sets count←0 and head←tail←0. Any enqueue that cycle is discarded. valid_out is 0 in the flush cycle.
- Reset (rst asserted, async):
  - count=0, pointers=0.
  - ready_in=1, valid_out=0.
  - Entry payload is not reset.
  - Reset mid-operation discards all entries immediately.
- Latency:
  - An instruction entering an empty queue is presented on valid_out the following cycle (1-cycle issue).
  - Throughput is 1/cycle with no hazards.
- Stall state machine (derived):
  - States EMPTY (count 0), ISSUE (count>0 & no hazard), STALL (count>0 & hazard).
  - STALL→ISSUE when ex_wb_en rises for the matching rd, or execute retires to a non-matching rd.
  - Any state→EMPTY on flush.

Optional Feature:
- Macro ID_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_issue_cnt (32) and perf_stall_cnt (32), both reset to 0.
  - perf_issue_cnt increments on each deq.
  - perf_stall_cnt increments each cycle in STALL.
  - Both wrap 0xFFFFFFFF→0.
  - Neither counter increments in a flush cycle.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Back-to-back independent ops: enqueue pc 0x80000000, 0x80000004 with ready_out=1 → valid_out on cycles 1 and 2, o_pc in order, ready_in never drops.
- Backpressure: ready_out=0, enqueue 3 instructions → count saturates at 2 and ready_in=0. Third is accepted only after ready_out=1; order 0x0,0x4,0x8 is preserved.
- Forward: head reads x5, ex_rd_idx=5, ex_rd_wen=1, ex_wb_en=1, ex_wb_dat=0xDEADBEEF, rf_rs1_dat=0x1 → o_rs1_dat=0xDEADBEEF, issued the same cycle.
- Load-use stall: head reads x7, ex_rd_idx=7, ex_wb_en=0 for 3 cycles, then 1 with data 0x55 → valid_out=0 for 3 cycles, then valid_out=1 with o_rs1_dat=0x55. With ID_PERF_CNT_EN, perf_stall_cnt=3.
- x0 source: rs2_idx=0, ex_rd_idx=0, ex_rd_wen=1, ex_wb_en=0 → no stall, o_rs2_dat=0.
- Flush with full queue plus simultaneous valid_in: flush_req=1 → next cycle count=0, valid_out=0, ready_in=1, and the incoming instruction is not issued. Asserting rst asynchronously mid-stall yields the same state.
